// File: rtl/fir_pkg.sv
// Shared sizing helpers, output saturation and the lower-part-OR addition
// used as the golden behaviour of the approximate accumulator.
package fir_pkg;

  function automatic int idx_w(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Clamp a sign-extended value into the signed data_w range.
  function automatic logic signed [63:0] sat_to_data(input logic signed [63:0] v,
                                                     input int data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Low lsb bits are ORed with no carry out; the upper fields add exactly.
  function automatic logic signed [63:0] approx_add(input logic signed [63:0] a,
                                                    input logic signed [63:0] b,
                                                    input int lsb,
                                                    input bit approx);
    logic signed [63:0] mask;
    logic signed [63:0] hi;
    if (!approx || lsb == 0) return a + b;
    mask = (64'sd1 <<< lsb) - 64'sd1;
    hi   = ((a >>> lsb) + (b >>> lsb)) <<< lsb;
    return hi | ((a | b) & mask);
  endfunction

endpackage

// File: rtl/fir_stream_approx_loa_adder.sv
// Lower-part-OR adder: with approx_en=1 the low APPROX_LSB bits are ORed and
// no carry reaches the upper field; with approx_en=0 it is a plain adder.
module loa_adder #(
  parameter int W          = 35,
  parameter int APPROX_LSB = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         approx_en,
  output logic [W-1:0] sum
);

  generate
    if (APPROX_LSB == 0) begin : g_exact
      logic unused_approx;
      assign unused_approx = approx_en;
      assign sum = a + b;
    end else begin : g_loa
      localparam int HW = W - APPROX_LSB;
      logic [APPROX_LSB:0] lo_sum;
      logic                carry;

      assign lo_sum = {1'b0, a[APPROX_LSB-1:0]} + {1'b0, b[APPROX_LSB-1:0]};
      assign carry  = lo_sum[APPROX_LSB] & ~approx_en;
      assign sum[W-1:APPROX_LSB] = a[W-1:APPROX_LSB] + b[W-1:APPROX_LSB] + HW'(carry);
      assign sum[APPROX_LSB-1:0] = approx_en ? (a[APPROX_LSB-1:0] | b[APPROX_LSB-1:0])
                                             : lo_sum[APPROX_LSB-1:0];
    end
  endgenerate

endmodule

// File: rtl/fir_stream_approx.sv
// Streaming N-tap direct-form FIR: product stage, fold/round/saturate stage,
// loadable coefficients and a switchable exact/approximate accumulator.
module fir_stream_approx
  import fir_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int TAPS       = 8,
  parameter int SHIFT      = 15,
  parameter int APPROX_LSB = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     coef_wr_en,
  input  logic [idx_w(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     approx_en
);

  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
  localparam int IDX_W  = idx_w(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [63:0] RND_ADD = (SHIFT > 0) ? (64'sd1 <<< RND_SH) : 64'sd0;

  logic signed [DATA_W-1:0] x_q    [TAPS];
  logic signed [DATA_W-1:0] x_d    [TAPS];
  logic signed [COEF_W-1:0] c_q    [TAPS];
  logic signed [COEF_W-1:0] c_d    [TAPS];
  logic signed [ACC_W-1:0]  p_q    [TAPS];
  logic signed [ACC_W-1:0]  p_d    [TAPS];
  logic signed [PROD_W-1:0] prod   [TAPS];
  logic signed [ACC_W-1:0]  fold   [TAPS];
  logic                     v1_q, v1_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     adv, accept;
  logic signed [63:0]       acc_ext, rnd, sat;

  assign adv       = !out_valid_q || out_ready;
  assign accept    = in_valid && adv;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    x_d[0] = accept ? in_data : x_q[0];
    for (int i = 1; i < TAPS; i++) begin
      x_d[i] = accept ? x_q[i-1] : x_q[i];
    end
  end

  // Products see the shifted delay line but the pre-write coefficients.
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_mul
      assign prod[gi] = PROD_W'(x_d[gi]) * PROD_W'(c_q[gi]);
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      c_d[i] = (coef_wr_en && coef_addr == IDX_W'(i)) ? coef_data : c_q[i];
      p_d[i] = accept ? ACC_W'(prod[i]) : p_q[i];
    end
    v1_d = adv ? accept : v1_q;
  end

  assign fold[0] = p_q[0];
  generate
    for (genvar gi = 1; gi < TAPS; gi++) begin : g_fold
      loa_adder #(
        .W          (ACC_W),
        .APPROX_LSB (APPROX_LSB)
      ) u_loa (
        .a         (fold[gi-1]),
        .b         (p_q[gi]),
        .approx_en (approx_en),
        .sum       (fold[gi])
      );
    end
  endgenerate

  always_comb begin
    acc_ext     = 64'(fold[TAPS-1]);
    rnd         = (acc_ext + RND_ADD) >>> SHIFT;
    sat         = sat_to_data(rnd, DATA_W);
    out_valid_d = adv ? v1_q : out_valid_q;
    out_data_d  = adv ? DATA_W'(sat) : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
        p_q[i] <= '0;
      end
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= x_d[i];
        c_q[i] <= c_d[i];
        p_q[i] <= p_d[i];
      end
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_fir_stream_approx.sv
// Bench for fir_stream_approx: an 8-tap instance checked against a queued
// reference model, plus a 2-tap SHIFT=0 instance for approx/collision cases.
module tb_fir_stream_approx;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               in_valid = 1'b0, out_ready = 1'b1, coef_wr_en = 1'b0, approx_en = 1'b0;
  logic               in_ready, out_valid;
  logic signed [15:0] in_data = '0, coef_data = '0, out_data;
  logic [2:0]         coef_addr = '0;

  logic               in_valid2 = 1'b0, out_ready2 = 1'b1, coef_wr_en2 = 1'b0, approx_en2 = 1'b0;
  logic               in_ready2, out_valid2;
  logic signed [15:0] in_data2 = '0, coef_data2 = '0, out_data2;
  logic               coef_addr2 = 1'b0;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] ref_x [8];
  logic signed [15:0] ref_c [8];
  logic signed [15:0] exp_q [$];

  fir_stream_approx #(.DATA_W(16), .COEF_W(16), .TAPS(8), .SHIFT(15), .APPROX_LSB(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
    .approx_en(approx_en)
  );

  fir_stream_approx #(.DATA_W(16), .COEF_W(16), .TAPS(2), .SHIFT(0), .APPROX_LSB(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .coef_wr_en(coef_wr_en2), .coef_addr(coef_addr2), .coef_data(coef_data2),
    .approx_en(approx_en2)
  );

  // Reference for the 8-tap instance: fold, round half up at bit 14, clamp.
  function automatic logic signed [15:0] model_out(input logic apx);
    logic signed [63:0] acc;
    logic signed [63:0] r;
    acc = 64'sd0;
    for (int i = 0; i < 8; i++)
      acc = approx_add(acc, longint'(ref_x[i]) * longint'(ref_c[i]), 4, apx);
    r = (acc + 64'sd16384) >>> 15;
    if (r > 64'sd32767) r = 64'sd32767;
    else if (r < -64'sd32768) r = -64'sd32768;
    return r[15:0];
  endfunction

  // Scoreboard: push on accept, pop on output handshake, all at the negedge.
  initial begin
    logic signed [15:0] expv;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          ref_x[i] = '0;
          ref_c[i] = '0;
        end
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: out_data=%0d, required no output", out_data);
          end else begin
            expv = exp_q.pop_front();
            if (out_data !== expv) begin
              errors++;
              $display("FAIL sb_data: out_data=%0d, required %0d", out_data, expv);
            end else begin
              $display("out %0d ok", out_data);
            end
          end
        end
        if (in_valid && in_ready) begin
          for (int i = 7; i > 0; i--) ref_x[i] = ref_x[i-1];
          ref_x[0] = in_data;
          exp_q.push_back(model_out(approx_en));
        end
        if (coef_wr_en) ref_c[coef_addr] = coef_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_valid2 = 1'b0; coef_wr_en = 1'b0; coef_wr_en2 = 1'b0;
    out_ready = 1'b1; out_ready2 = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic write_coef(input logic [2:0] a, input logic signed [15:0] d);
    coef_wr_en = 1'b1; coef_addr = a; coef_data = d;
    step();
    coef_wr_en = 1'b0;
  endtask

  task automatic write_coef2(input logic a, input logic signed [15:0] d);
    coef_wr_en2 = 1'b1; coef_addr2 = a; coef_data2 = d;
    step();
    coef_wr_en2 = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++;
    if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    checks++;
    if (out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_out_valid2: got %b, required 0", out_valid2); end
    step();
  endtask

  task automatic test_impulse();
    do_reset();
    write_coef(3'd0, 16'sd16384);
    write_coef(3'd1, 16'sd8192);
    in_valid = 1'b1; in_data = 16'sd1000;
    step();
    in_data = 16'sd0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL impulse_early: out_valid=%b, required 0", out_valid); end
    step();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd500) begin
      errors++;
      $display("FAIL impulse_first: valid=%b data=%0d, required 1/500", out_valid, out_data);
    end
    step();
    repeat (4) step();
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL impulse_drain: %0d missing, required 0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 8; i++) write_coef(3'(i), 16'sd32767);
    in_valid = 1'b1; in_data = 16'sd32767;
    repeat (10) step();
    @(negedge clk);
    checks++;
    if (out_data !== 16'sd32767) begin errors++; $display("FAIL sat_pos: got %0d, required 32767", out_data); end
    step();
    in_data = 16'sh8000;
    repeat (10) step();
    @(negedge clk);
    checks++;
    if (out_data !== 16'sh8000) begin errors++; $display("FAIL sat_neg: got %0d, required -32768", out_data); end
    step();
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sat_drain: %0d missing, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int n;
    int cyc;
    do_reset();
    for (int i = 0; i < 8; i++) write_coef(3'(i), 16'(i * 3000 - 9000));
    n = 1;
    for (cyc = 0; cyc < 100 && n <= 20; cyc++) begin
      out_ready = !(cyc >= 8 && cyc < 13);
      in_valid = 1'b1; in_data = 16'(n * 1000);
      @(negedge clk);
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b, required 1", out_valid); end
        checks++;
        if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL bp_hold: out_data=%0d, required pending output (queue %0d)", out_data, exp_q.size());
        end
      end
      if (in_valid && in_ready) n++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (n <= 20) begin errors++; $display("FAIL bp_accept: accepted %0d, required 20", n - 1); end
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: %0d missing, required 0", exp_q.size()); end
  endtask

  task automatic test_approx_stream();
    do_reset();
    approx_en = 1'b1;
    for (int i = 0; i < 8; i++) write_coef(3'(i), 16'($urandom));
    in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_data = 16'($urandom);
      step();
    end
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL apxs_drain: %0d missing, required 0", exp_q.size()); end
    approx_en = 1'b0;
  endtask

  task automatic test_approx();
    do_reset();
    write_coef2(1'b0, 16'sd1);
    write_coef2(1'b1, 16'sd1);
    approx_en2 = 1'b0;
    in_valid2 = 1'b1; in_data2 = 16'sd9;
    step();
    in_data2 = 16'sd7;
    step();
    in_valid2 = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 16'sd9) begin
      errors++;
      $display("FAIL apx_first: valid=%b data=%0d, required 1/9", out_valid2, out_data2);
    end
    step();
    @(negedge clk);
    checks++;
    if (out_data2 !== 16'sd16) begin errors++; $display("FAIL apx_exact: got %0d, required 16", out_data2); end
    step();
    approx_en2 = 1'b1;
    in_valid2 = 1'b1; in_data2 = 16'sd9;
    step();
    in_data2 = 16'sd7;
    step();
    in_valid2 = 1'b0;
    @(negedge clk);
    checks++;
    if (out_data2 !== 16'sd15) begin errors++; $display("FAIL apx_or_a: got %0d, required 15", out_data2); end
    step();
    @(negedge clk);
    checks++;
    if (out_data2 !== 16'sd15) begin errors++; $display("FAIL apx_or_b: got %0d, required 15", out_data2); end
    step();
    approx_en2 = 1'b0;
  endtask

  task automatic test_coef_collision();
    do_reset();
    write_coef2(1'b0, 16'sd1);
    coef_wr_en2 = 1'b1; coef_addr2 = 1'b0; coef_data2 = 16'sd2;
    in_valid2 = 1'b1; in_data2 = 16'sd100;
    step();
    coef_wr_en2 = 1'b0;
    step();
    in_valid2 = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 16'sd100) begin
      errors++;
      $display("FAIL coef_old: valid=%b data=%0d, required 1/100", out_valid2, out_data2);
    end
    step();
    @(negedge clk);
    checks++;
    if (out_data2 !== 16'sd200) begin errors++; $display("FAIL coef_new: got %0d, required 200", out_data2); end
    step();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    write_coef(3'd0, 16'sd16384);
    write_coef(3'd1, 16'sd16384);
    in_valid = 1'b1; in_data = 16'sd2000;
    repeat (4) step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b, required 0", out_valid); end
    checks++;
    if (out_data !== 16'sd0) begin errors++; $display("FAIL rstmid_data: got %0d, required 0", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, required 1", in_ready); end
    step();
    in_valid = 1'b1; in_data = 16'sd3000;
    repeat (2) step();
    in_valid = 1'b0;
    write_coef(3'd0, 16'sd16384);
    in_valid = 1'b1; in_data = 16'sd4000;
    step();
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_drain: %0d missing, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_approx_stream();
    test_approx();
    test_coef_collision();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
